// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared FSM encoding and word/byte helpers for rv_multiport_mem
package rv_mem_pkg;
    localparam int MAX_W = 256;
    localparam int MAX_B = MAX_W / 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [MAX_W-1:0] byte_merge(
        input logic [MAX_W-1:0] old_w,
        input logic [MAX_W-1:0] new_w,
        input logic [MAX_B-1:0] strb
    );
        logic [MAX_W-1:0] r;
        r = old_w;
        for (int b = 0; b < MAX_B; b++)
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [63:0] word_index(input logic [63:0] addr, input int unsigned bytes);
        return addr >> $clog2(bytes);
    endfunction
endpackage

// File: rtl/rv_mem_rdport.sv
// rv_mem_rdport: one read port with range check, write bypass and optional output register
module rv_mem_rdport
    import rv_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10,
    parameter int RD_LATENCY  = 1,
    parameter int BYPASS      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ready,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   rd_word,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_idx,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [AW-1:0]       rd_idx,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                rd_fault
);
    logic [63:0] widx;
    logic in_range, hit, valid_c, fault_c, valid_q, fault_q;
    logic [DATA_W-1:0] merged, data_c, data_q;

    assign widx     = word_index(64'(rd_addr), DATA_W / 8);
    assign in_range = widx < 64'(DEPTH_WORDS);
    assign rd_idx   = widx[AW-1:0];
    assign hit      = BYPASS != 0 && wr_en && wr_idx == rd_idx;
    assign merged   = hit ? DATA_W'(byte_merge(MAX_W'(rd_word), MAX_W'(wr_data), MAX_B'(wstrb))) : rd_word;
    assign data_c   = in_range ? merged : '0;
    assign valid_c  = rd_en && ready;
    assign fault_c  = valid_c && !in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_c;
            fault_q <= fault_c;
            if (valid_c) data_q <= data_c;
        end
    end

    assign rd_data  = RD_LATENCY == 0 ? data_c  : data_q;
    assign rd_valid = RD_LATENCY == 0 ? valid_c : valid_q;
    assign rd_fault = RD_LATENCY == 0 ? fault_c : fault_q;
endmodule

// File: rtl/rv_multiport_mem.sv
// rv_multiport_mem: NUM_RD read ports, one byte-strobed write port, zero-fill after reset
module rv_multiport_mem
    import rv_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int NUM_RD      = 2,
    parameter int RD_LATENCY  = 1,
    parameter int BYPASS      = 1
) (
    input  logic                     iwClk,
    input  logic                     iwRst,
    input  logic [NUM_RD-1:0]        iwRdEn,
    input  logic [NUM_RD*ADDR_W-1:0] iwRdAddr,
    output logic [NUM_RD*DATA_W-1:0] owRdData,
    output logic [NUM_RD-1:0]        owRdValid,
    output logic [NUM_RD-1:0]        owRdFault,
    input  logic [ADDR_W-1:0]        iwWrAddr,
    input  logic [DATA_W-1:0]        iwWrData,
    input  logic [DATA_W/8-1:0]      iwWstrb,
    output logic                     owWrFault,
    output logic                     owReady
);
    localparam int NB = DATA_W / 8;
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    state_t state, state_n;
    logic [AW-1:0] cnt, wr_idx;
    logic [63:0] wr_widx;
    logic wr_req, wr_in, wr_en, wr_fault;
    logic [AW-1:0] rd_idx [NUM_RD];
    logic [DATA_W-1:0] rd_word [NUM_RD];

    assign wr_widx   = word_index(64'(iwWrAddr), NB);
    assign wr_in     = wr_widx < 64'(DEPTH_WORDS);
    assign wr_idx    = wr_widx[AW-1:0];
    assign wr_req    = state == ST_RUN && |iwWstrb;
    assign wr_en     = wr_req && wr_in && !iwRst;
    assign owReady   = state == ST_RUN;
    assign owWrFault = wr_fault;

    always_comb state_n = (state == ST_INIT && cnt == AW'(DEPTH_WORDS - 1)) ? ST_RUN : state;

    always_ff @(posedge iwClk) begin
        if (iwRst) begin
            state    <= ST_INIT;
            cnt      <= '0;
            wr_fault <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= state == ST_INIT ? cnt + 1'b1 : cnt;
            wr_fault <= wr_req && !wr_in;
        end
    end

    // storage has no reset; the INIT sweep zeroes it one word per cycle
    always_ff @(posedge iwClk) begin
        if (!iwRst && state == ST_INIT)
            mem[cnt] <= '0;
        else if (wr_en)
            mem[wr_idx] <= DATA_W'(byte_merge(MAX_W'(mem[wr_idx]), MAX_W'(iwWrData), MAX_B'(iwWstrb)));
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign rd_word[k] = mem[rd_idx[k]];
        rv_mem_rdport #(
            .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH_WORDS),
            .AW(AW), .RD_LATENCY(RD_LATENCY), .BYPASS(BYPASS)
        ) u_rd (
            .clk(iwClk),
            .rst(iwRst),
            .ready(owReady),
            .rd_en(iwRdEn[k]),
            .rd_addr(iwRdAddr[k*ADDR_W +: ADDR_W]),
            .rd_word(rd_word[k]),
            .wr_en(wr_en),
            .wr_idx(wr_idx),
            .wr_data(iwWrData),
            .wstrb(iwWstrb),
            .rd_idx(rd_idx[k]),
            .rd_data(owRdData[k*DATA_W +: DATA_W]),
            .rd_valid(owRdValid[k]),
            .rd_fault(owRdFault[k])
        );
    end
endmodule

// File: tb/tb_rv_multiport_mem.sv
// tb_rv_multiport_mem: directed checks of a registered/bypass instance and a combinational/no-bypass instance
module tb_rv_multiport_mem;
    logic clk = 1'b0;
    logic rst;
    logic [1:0] rd_en;
    logic [63:0] rd_addr;
    logic [31:0] wr_addr, wr_data;
    logic [3:0] wstrb;
    logic [63:0] a_data, b_data;
    logic [1:0] a_valid, a_fault, b_valid, b_fault;
    logic a_wf, a_rdy, b_wf, b_rdy;
    int tests = 0;
    int fails = 0;
    int n;

    always #5 clk = ~clk;

    rv_multiport_mem #(.DEPTH_WORDS(16), .NUM_RD(2), .RD_LATENCY(1), .BYPASS(1)) u_a (
        .iwClk(clk), .iwRst(rst), .iwRdEn(rd_en), .iwRdAddr(rd_addr),
        .owRdData(a_data), .owRdValid(a_valid), .owRdFault(a_fault),
        .iwWrAddr(wr_addr), .iwWrData(wr_data), .iwWstrb(wstrb),
        .owWrFault(a_wf), .owReady(a_rdy)
    );

    rv_multiport_mem #(.DEPTH_WORDS(16), .NUM_RD(2), .RD_LATENCY(0), .BYPASS(0)) u_b (
        .iwClk(clk), .iwRst(rst), .iwRdEn(rd_en), .iwRdAddr(rd_addr),
        .owRdData(b_data), .owRdValid(b_valid), .owRdFault(b_fault),
        .iwWrAddr(wr_addr), .iwWrData(wr_data), .iwWstrb(wstrb),
        .owWrFault(b_wf), .owReady(b_rdy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rd_en = 2'b00;
        wstrb = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a0, input logic [31:0] a1);
        rd_en   = 2'b11;
        rd_addr = {a1, a0};
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_addr = a;
        wr_data = d;
        wstrb   = s;
    endtask

    initial begin
        rst = 1'b1;
        rd_en = 2'b00; rd_addr = '0; wr_addr = '0; wr_data = '0; wstrb = '0;
        repeat (3) tick();
        chk("rst_ready", {a_rdy, b_rdy}, 2'b00);
        chk("rst_valid", {a_valid, b_valid}, 4'b0000);
        chk("rst_faults", {a_fault, a_wf, b_wf}, 4'b0000);
        chk("rst_rdata", a_data, 64'h0);

        // requests during INIT must be ignored
        rst = 1'b0;
        rd(32'h0, 32'h4);
        wr(32'h0, 32'hFFFF_FFFF, 4'hF);
        tick();
        n = 1;
        chk("init_valid", {a_valid, b_valid}, 4'b0000);
        chk("init_wfault", {a_wf, b_wf}, 2'b00);
        idle();
        while (!a_rdy && n < 40) begin
            tick();
            n++;
        end
        chk("ready_cycles", n, 16);
        chk("ready_both", {a_rdy, b_rdy}, 2'b11);

        for (int w = 0; w < 16; w++) begin
            rd(32'(4 * w), 32'(4 * w));
            chk("zero_comb", {b_data, 2'(b_valid), 2'(b_fault)}, {64'h0, 2'b11, 2'b00});
            tick();
            chk("zero_reg", {a_data, 2'(a_valid), 2'(a_fault)}, {64'h0, 2'b11, 2'b00});
        end
        idle();

        wr(32'h10, 32'hDEAD_BEEF, 4'hF);
        tick();
        wr(32'h10, 32'h0000_AA00, 4'b0010);
        tick();
        idle();
        rd(32'h10, 32'h13);
        chk("strb_comb", b_data, {32'hDEAD_AAEF, 32'hDEAD_AAEF});
        tick();
        chk("strb_reg", a_data, {32'hDEAD_AAEF, 32'hDEAD_AAEF});

        rd(32'h10, 32'h20);
        wr(32'h20, 32'h1234_5678, 4'hF);
        chk("nobyp_comb", b_data, {32'h0, 32'hDEAD_AAEF});
        tick();
        chk("byp_reg", a_data, {32'h1234_5678, 32'hDEAD_AAEF});
        wr(32'h20, 32'h0000_00AB, 4'b0001);
        #1;
        chk("nobyp_part", b_data[63:32], 32'h1234_5678);
        tick();
        chk("byp_part", a_data[63:32], 32'h1234_56AB);
        idle();

        wr(32'h0, 32'h11, 4'hF);
        tick();
        wr(32'h4, 32'h22, 4'hF);
        tick();
        idle();
        rd(32'h0, 32'h4);
        chk("dual_comb", {b_data, 2'(b_valid)}, {32'h22, 32'h11, 2'b11});
        tick();
        chk("dual_reg", {a_data, 2'(a_valid)}, {32'h22, 32'h11, 2'b11});

        rd(32'h40, 32'h0);
        chk("oor_comb", {b_data, 2'(b_valid), 2'(b_fault)}, {32'h11, 32'h0, 2'b11, 2'b01});
        tick();
        chk("oor_reg", {a_data, 2'(a_valid), 2'(a_fault)}, {32'h11, 32'h0, 2'b11, 2'b01});
        idle();
        tick();
        chk("hold_valid", {a_valid, a_fault}, 4'b0000);
        chk("hold_data", a_data, {32'h11, 32'h0});

        wr(32'h40, 32'hFFFF_FFFF, 4'hF);
        tick();
        idle();
        chk("wfault_pulse", {a_wf, b_wf}, 2'b11);
        tick();
        chk("wfault_clear", {a_wf, b_wf}, 2'b00);
        rd(32'h0, 32'h0);
        chk("oor_nowrite_comb", b_data, {32'h11, 32'h11});
        tick();
        chk("oor_nowrite_reg", a_data, {32'h11, 32'h11});
        idle();

        // reset in RUN, then again part-way through the fill sweep
        rst = 1'b1;
        tick();
        chk("rerun_ready", {a_rdy, b_rdy, a_valid}, 4'b0000);
        rst = 1'b0;
        repeat (7) tick();
        chk("mid_init_ready", {a_rdy, b_rdy}, 2'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (!a_rdy && n < 40) begin
            tick();
            n++;
        end
        chk("reinit_cycles", n, 16);
        rd(32'h0, 32'h10);
        chk("reinit_comb", b_data, 64'h0);
        tick();
        chk("reinit_reg", {a_data, 2'(a_valid)}, {64'h0, 2'b11});
        rd(32'h4, 32'h20);
        chk("reinit_comb2", b_data, 64'h0);
        tick();
        chk("reinit_reg2", a_data, 64'h0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rv_multiport_mem.md
Name: rv_multiport_mem

Overview:
Parametrised data/instruction memory for the ice-risc RV core. It generalises the core's fixed bus of two read addresses and one strobed write into NUM_RD read ports and one byte-strobed write port. Read latency is configurable, with optional write-to-read bypass, address fault flags, and a post-reset zero-fill sequencer. It sits directly on the core's memory bus, below the core top level.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8
ADDR_W, 32, byte-address width
DEPTH_WORDS, 1024, number of words; must be a power of 2
NUM_RD, 2, number of independent read ports (1..4)
RD_LATENCY, 1, read latency in cycles: 0 = combinational read, 1 = registered read
BYPASS, 1, 1 = a read of the word written in the same cycle returns the merged new data

Ports:
iwClk  input  1  clock; all state on rising edge
iwRst  input  1  synchronous reset, active-high
iwRdEn  input  NUM_RD  per-port read request
iwRdAddr  input  NUM_RD*ADDR_W  byte addresses; port k occupies [k*ADDR_W +: ADDR_W]
owRdData  output  NUM_RD*DATA_W  read data; port k occupies [k*DATA_W +: DATA_W]
owRdValid  output  NUM_RD  read data valid, per port
owRdFault  output  NUM_RD  out-of-range read, aligned with owRdValid
iwWrAddr  input  ADDR_W  write byte address
iwWrData  input  DATA_W  write data
iwWstrb  input  DATA_W/8  byte strobes; all-zero means no write
owWrFault  output  1  out-of-range write attempted (registered, 1-cycle pulse)
owReady  output  1  high once zero-fill is complete

Behaviour:
- Word index = addr >> log2(DATA_W/8). Low byte-offset bits are ignored, so there is no misalignment handling. An address is in range iff word index < DEPTH_WORDS.
- Reset (iwRst=1 at an edge):
  - owReady=0; all owRdValid, owRdFault, owWrFault and registered owRdData = 0.
  - FSM enters INIT with fill counter = 0.
- FSM INIT:
  - One word written to zero per cycle at index = counter; counter increments.
  - The cycle that writes DEPTH_WORDS-1 transitions to RUN. owReady=1 from the next cycle, i.e. exactly DEPTH_WORDS cycles after reset deassertion.
  - While in INIT, read and write requests are ignored: owRdValid=0, no faults, no user writes.
- FSM RUN: terminal until reset. Reset asserted mid-INIT or mid-RUN restarts INIT from counter 0.
- Write (RUN): if iwWstrb!=0 and in range, byte b of the word is updated from iwWrData[8b+:8] where iwWstrb[b]=1 at the edge. Other bytes are unchanged.
- Write out of range: memory unchanged; owWrFault=1 for the next cycle only.
- Read, RD_LATENCY=0:
  - owRdValid[k] = iwRdEn[k] & ready, combinational.
  - owRdData = word contents before the current edge's write.
  - If BYPASS=1 and the same word is being written, the strobed bytes are replaced by iwWrData.
- Read, RD_LATENCY=1:
  - Request sampled at edge N; data, valid and fault appear after edge N, i.e. during cycle N+1.
  - With BYPASS=1, a same-word write at edge N yields the merged new data. With BYPASS=0 it yields the old data.
  - owRdValid drops the cycle after iwRdEn drops. owRdData holds its last value when not valid.
- Read out of range: owRdData=0, owRdValid=1, owRdFault=1, with the same latency as a normal read.
- Multiple read ports may read the same word in the same cycle; all return identical data. There is no arbitration and no stall.
- Write during INIT is dropped silently, with no fault.

Decomposition:
- Shared package rv_mem_pkg holds:
  - FSM state encoding ST_INIT=1'b0, ST_RUN=1'b1.
  - Function byte_merge(old, new, strb).
  - Function word_index(addr) → clog2-based shift.
- One sub-module, rv_mem_rdport: per-port range check, bypass merge and latency register. It is instantiated NUM_RD times by generate.
- Storage array, write logic and INIT FSM live in the top block.

Test Plan:
- Reset release, DEPTH_WORDS=16 → owReady rises exactly 16 cycles after iwRst falls. Afterwards, reading every word on both ports returns 0x00000000 with owRdFault=0.
- Write 0xDEADBEEF to addr 0x10 with wstrb=4'hF, then wstrb=4'b0010 with data 0x0000AA00 → read port 0 at 0x10 returns 0xDEADAAEF. Reading 0x13 (misaligned) returns the same value.
- RD_LATENCY=1, BYPASS=1: same-cycle write 0x12345678 and port-1 read of 0x20 (previously 0) → data 0x12345678 one cycle later. With BYPASS=0 the result is 0x00000000.
- NUM_RD=2: port 0 reads 0x0 while port 1 reads 0x4 in the same cycle (holding 0x11 and 0x22) → 0x11 and 0x22 appear simultaneously, both valid.
- DEPTH_WORDS=16: read 0x40 → owRdFault=1, owRdData=0. Write 0x40 → owWrFault pulses for 1 cycle and word 0 is unchanged.
- Assert iwRst for 1 cycle at INIT counter=7, then again in RUN after writes → INIT restarts each time, owReady low for 16 cycles, and all previously written data reads 0.
